// File: rtl/lock_pkg.sv
// Shared constants and types for the digital lock: digit geometry, BCD limit, code type.
package lock_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BCD_MAX    = 9;

  typedef logic [NUM_DIGITS*DIGIT_W-1:0] code_t;

  localparam code_t DEFAULT_CODE = 16'h1234;
endpackage

// File: rtl/code_entry_buffer_if.sv
// Keypad/control-FSM side bus of the code entry buffer.
// master = keypad + control FSM, slave = code_entry_buffer.
interface code_entry_buffer_if #(
  parameter int NUM_DIGITS = lock_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = lock_pkg::DIGIT_W
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               ready_for_input;
  logic               attempt_done;
  logic               clear;
  logic               prog_req;
  logic               prog_allow;
  logic               full;
  logic               match;
  logic [CNT_W-1:0]   digit_count;
  logic               key_err;
  logic               prog_ack;

  modport master (
    output key_valid, key_digit, ready_for_input, attempt_done, clear, prog_req, prog_allow,
    input  full, match, digit_count, key_err, prog_ack
  );

  modport slave (
    input  key_valid, key_digit, ready_for_input, attempt_done, clear, prog_req, prog_allow,
    output full, match, digit_count, key_err, prog_ack
  );
endinterface

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-clock rising-edge pulse.
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  // sr[1:0] synchronise, sr[2] holds the previous synchronised level
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/code_entry_buffer.sv
// Keypad digit collector: accumulates BCD digits, flags full/match for the lock FSM.
// Optional code programming is enabled by defining CODE_PROG_EN.
module code_entry_buffer #(
  parameter int NUM_DIGITS = lock_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = lock_pkg::DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE
) (
  input logic                clk,
  input logic                rst_n,
  code_entry_buffer_if.slave bus
);
  import lock_pkg::*;

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);

  typedef logic [CODE_W-1:0] buf_t;

  buf_t             buffer, buffer_nx, code_reg;
  logic [CNT_W-1:0] count, count_nx;
  logic             full_q, match_q, err_q;
  logic             full_nx, match_nx, err_nx;
  logic             key_stb, digit_ok, prog_take;

  key_edge_sync u_key_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.key_valid),
    .pulse    (key_stb)
  );

  assign digit_ok = int'(bus.key_digit) <= BCD_MAX;

`ifdef CODE_PROG_EN
  buf_t code_nx;
  logic ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg <= DEFAULT_CODE;
      ack_q    <= 1'b0;
    end else begin
      code_reg <= code_nx;
      ack_q    <= prog_take;
    end
  end

  assign bus.prog_ack = ack_q;
`else
  logic unused_prog;
  assign unused_prog  = bus.prog_req ^ bus.prog_allow;
  assign code_reg     = DEFAULT_CODE;
  assign bus.prog_ack = 1'b0;
`endif

  // Priority: clear/attempt_done, then programming, then the key strobe.
  always_comb begin
    buffer_nx = buffer;
    count_nx  = count;
    err_nx    = 1'b0;
    prog_take = 1'b0;
`ifdef CODE_PROG_EN
    code_nx   = code_reg;
`endif
    if (bus.clear || bus.attempt_done) begin
      buffer_nx = '0;
      count_nx  = '0;
    end else begin
`ifdef CODE_PROG_EN
      if (bus.prog_req) begin
        if (bus.prog_allow && full_q) begin
          prog_take = 1'b1;
          code_nx   = buffer;
          buffer_nx = '0;
          count_nx  = '0;
        end else begin
          err_nx = 1'b1;
        end
      end
`endif
      if (key_stb && !prog_take) begin
        if (bus.ready_for_input && !full_q && digit_ok) begin
          buffer_nx = (buffer << DIGIT_W) | CODE_W'(bus.key_digit);
          count_nx  = count + CNT_W'(1);
        end else begin
          err_nx = 1'b1;
        end
      end
    end
  end

  // Qualifiers come from next state so they move on the same edge as the digit write.
  assign full_nx  = (count_nx == CNT_MAX);
  assign match_nx = full_nx && (buffer_nx == code_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buffer  <= buffer_nx;
      count   <= count_nx;
      full_q  <= full_nx;
      match_q <= match_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.full        = full_q;
  assign bus.match       = match_q;
  assign bus.digit_count = count;
  assign bus.key_err     = err_q;
endmodule

// File: tb/tb_code_entry_buffer.sv
// Directed bench for code_entry_buffer; covers both CODE_PROG_EN builds.
module tb_code_entry_buffer;
  import lock_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  code_entry_buffer_if bus ();

  code_entry_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise the strobe and return at the sample point just after the write edge.
  task automatic key_begin(input logic [3:0] d);
    @(negedge clk);
    bus.key_digit = d;
    bus.key_valid = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic key_end();
    repeat (2) @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    key_begin(d);
    key_end();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.full, bus.match, bus.digit_count, bus.key_err, bus.prog_ack} !== 7'b0) begin
      $display("FAIL reset_outputs got=%b want=0", {bus.full, bus.match, bus.digit_count, bus.key_err, bus.prog_ack});
      failures++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry_match();
    @(negedge clk);
    bus.key_digit = 4'd1;
    bus.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.digit_count !== 3'd0) begin
      $display("FAIL latency_before_write count=%0d want=0", bus.digit_count); failures++;
    end
    @(negedge clk);
    checks++;
    if (bus.digit_count !== 3'd1 || bus.full !== 1'b0) begin
      $display("FAIL first_digit count=%0d full=%b want 1/0", bus.digit_count, bus.full); failures++;
    end
    key_end();
    for (int i = 2; i <= 4; i++) begin
      key_begin(4'(i));
      checks++;
      if (bus.digit_count !== 3'(i)) begin
        $display("FAIL count_step%0d count=%0d want=%0d", i, bus.digit_count, i); failures++;
      end
      key_end();
    end
    checks++;
    if (bus.full !== 1'b1 || bus.match !== 1'b1) begin
      $display("FAIL code_1234 full=%b match=%b want 1/1", bus.full, bus.match); failures++;
    end
  endtask

  task automatic test_errors();
    key_begin(4'd7);
    checks++;
    if (bus.key_err !== 1'b1 || bus.digit_count !== 3'd4 || bus.match !== 1'b1) begin
      $display("FAIL full_reject err=%b count=%0d match=%b want 1/4/1", bus.key_err, bus.digit_count, bus.match); failures++;
    end
    @(negedge clk);
    checks++;
    if (bus.key_err !== 1'b0) begin
      $display("FAIL err_one_clk err=%b want=0", bus.key_err); failures++;
    end
    key_end();
    pulse_clear();
    checks++;
    if (bus.digit_count !== 3'd0 || bus.full !== 1'b0 || bus.match !== 1'b0) begin
      $display("FAIL clear count=%0d full=%b match=%b want 0/0/0", bus.digit_count, bus.full, bus.match); failures++;
    end
    key_begin(4'hA);
    checks++;
    if (bus.key_err !== 1'b1 || bus.digit_count !== 3'd0) begin
      $display("FAIL non_bcd err=%b count=%0d want 1/0", bus.key_err, bus.digit_count); failures++;
    end
    key_end();
    key_begin(4'd9);
    checks++;
    if (bus.key_err !== 1'b0 || bus.digit_count !== 3'd1) begin
      $display("FAIL digit9_ok err=%b count=%0d want 0/1", bus.key_err, bus.digit_count); failures++;
    end
    key_end();
    bus.ready_for_input = 1'b0;
    key_begin(4'd5);
    checks++;
    if (bus.key_err !== 1'b1 || bus.digit_count !== 3'd1) begin
      $display("FAIL not_ready err=%b count=%0d want 1/1", bus.key_err, bus.digit_count); failures++;
    end
    key_end();
    bus.ready_for_input = 1'b1;
    pulse_clear();
  endtask

  task automatic test_wrong_code();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5);
    checks++;
    if (bus.full !== 1'b1 || bus.match !== 1'b0) begin
      $display("FAIL code_1235 full=%b match=%b want 1/0", bus.full, bus.match); failures++;
    end
    @(negedge clk);
    bus.attempt_done = 1'b1;
    @(negedge clk);
    bus.attempt_done = 1'b0;
    checks++;
    if (bus.digit_count !== 3'd0 || bus.full !== 1'b0 || bus.match !== 1'b0) begin
      $display("FAIL attempt_done count=%0d full=%b match=%b want 0/0/0", bus.digit_count, bus.full, bus.match); failures++;
    end
  endtask

  task automatic test_clear_vs_key();
    press(4'd3);
    @(negedge clk);
    bus.key_digit = 4'd6;
    bus.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    checks++;
    if (bus.digit_count !== 3'd0 || bus.key_err !== 1'b0) begin
      $display("FAIL clear_beats_key count=%0d err=%b want 0/0", bus.digit_count, bus.key_err); failures++;
    end
    key_end();
    key_begin(4'd1);
    checks++;
    if (bus.digit_count !== 3'd1) begin
      $display("FAIL after_clear count=%0d want=1", bus.digit_count); failures++;
    end
    key_end();
    pulse_clear();
  endtask

  task automatic test_async_reset();
    press(4'd4); press(4'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.digit_count !== 3'd0 || bus.full !== 1'b0 || bus.match !== 1'b0 || bus.key_err !== 1'b0) begin
      $display("FAIL async_reset count=%0d full=%b match=%b err=%b want 0", bus.digit_count, bus.full, bus.match, bus.key_err); failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    key_begin(4'd8);
    checks++;
    if (bus.digit_count !== 3'd1) begin
      $display("FAIL reentry count=%0d want=1", bus.digit_count); failures++;
    end
    key_end();
    pulse_clear();
  endtask

  task automatic test_prog();
    bus.prog_allow = 1'b1;
`ifdef CODE_PROG_EN
    press(4'd9);
    @(negedge clk);
    bus.prog_req = 1'b1;
    @(negedge clk);
    bus.prog_req = 1'b0;
    checks++;
    if (bus.key_err !== 1'b1 || bus.prog_ack !== 1'b0 || bus.digit_count !== 3'd1) begin
      $display("FAIL prog_not_full err=%b ack=%b count=%0d want 1/0/1", bus.key_err, bus.prog_ack, bus.digit_count); failures++;
    end
    press(4'd8); press(4'd7); press(4'd6);
    @(negedge clk);
    bus.prog_req = 1'b1;
    @(negedge clk);
    bus.prog_req = 1'b0;
    checks++;
    if (bus.prog_ack !== 1'b1 || bus.digit_count !== 3'd0 || bus.full !== 1'b0) begin
      $display("FAIL prog_store ack=%b count=%0d full=%b want 1/0/0", bus.prog_ack, bus.digit_count, bus.full); failures++;
    end
    @(negedge clk);
    checks++;
    if (bus.prog_ack !== 1'b0) begin
      $display("FAIL ack_one_clk ack=%b want=0", bus.prog_ack); failures++;
    end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    checks++;
    if (bus.match !== 1'b1) begin
      $display("FAIL new_code_match match=%b want=1", bus.match); failures++;
    end
    pulse_clear();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++;
    if (bus.full !== 1'b1 || bus.match !== 1'b0) begin
      $display("FAIL old_code_rejected full=%b match=%b want 1/0", bus.full, bus.match); failures++;
    end
`else
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    @(negedge clk);
    bus.prog_req = 1'b1;
    @(negedge clk);
    bus.prog_req = 1'b0;
    checks++;
    if (bus.prog_ack !== 1'b0 || bus.digit_count !== 3'd4 || bus.key_err !== 1'b0) begin
      $display("FAIL prog_ignored ack=%b count=%0d err=%b want 0/4/0", bus.prog_ack, bus.digit_count, bus.key_err); failures++;
    end
    checks++;
    if (bus.match !== 1'b1) begin
      $display("FAIL default_code_match match=%b want=1", bus.match); failures++;
    end
`endif
    bus.prog_allow = 1'b0;
    pulse_clear();
  endtask

  initial begin
    bus.key_valid       = 1'b0;
    bus.key_digit       = '0;
    bus.ready_for_input = 1'b1;
    bus.attempt_done    = 1'b0;
    bus.clear           = 1'b0;
    bus.prog_req        = 1'b0;
    bus.prog_allow      = 1'b0;
    test_reset();
    test_entry_match();
    test_errors();
    test_wrong_code();
    test_clear_vs_key();
    test_async_reset();
    test_prog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
